// File: rtl/rb_sequencer.sv
// -----------------------------------------------------------------------------
// rb_sequencer
//
// Multi-cycle control/datapath front end for an 8 x WIDTH register bank with a
// single shared address port. One instruction is accepted per Run handshake in
// IDLE. The sequencer then walks the bank's port through read and write-back
// cycles to execute mv, mvi, add or sub. Opcodes 4-15 are nops.
//
// Ports
//   Clock       in   rising-edge clock
//   reset       in   asynchronous, active-low reset
//   Run         in   instruction-valid request, sampled only in IDLE
//   DIN         in   instruction word; carries the immediate during mvi's T1
//   q           in   combinational bank read data for rb_addr
//   rb_addr     out  bank address, shared by reads and writes
//   rb_wr       out  bank write enable
//   rb_data     out  bank write data
//   rb_incr_pc  out  R7 increment strobe (fetch advance / immediate skip)
//   Done        out  one-cycle pulse on an instruction's final cycle
//   Busy        out  high whenever the sequencer is not in IDLE
//
// Instruction word: [15:12] opcode, [11:9] X, [8:6] Y, [5:0] ignored.
// -----------------------------------------------------------------------------
module rb_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             reset,
  input  logic             Run,
  input  logic [WIDTH-1:0] DIN,
  input  logic [WIDTH-1:0] q,
  output logic [2:0]       rb_addr,
  output logic             rb_wr,
  output logic [WIDTH-1:0] rb_data,
  output logic             rb_incr_pc,
  output logic             Done,
  output logic             Busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_t;

  localparam logic [3:0] OP_MV  = 4'd0;
  localparam logic [3:0] OP_MVI = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [2:0] PC_REG = 3'd7;

  // The operand-free low six bits of the instruction are never consulted, so
  // only the opcode and register fields are held in IR.
  state_t           state_q, state_d;
  logic [WIDTH-1:6] ir_q, ir_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] g_q, g_d;

  // Decoded view of the held instruction.
  logic [3:0] op;
  logic [2:0] x_sel;
  logic [2:0] y_sel;
  logic       is_mv;
  logic       is_mvi;
  logic       is_add;
  logic       is_sub;
  logic       is_arith;

  assign op       = ir_q[15:12];
  assign x_sel    = ir_q[11:9];
  assign y_sel    = ir_q[8:6];
  assign is_mv    = (op == OP_MV);
  assign is_mvi   = (op == OP_MVI);
  assign is_add   = (op == OP_ADD);
  assign is_sub   = (op == OP_SUB);
  assign is_arith = is_add | is_sub;

  // Combinational output shadows; the increment request is resolved against
  // the write-wins rule before it leaves the block.
  logic [2:0]       addr_c;
  logic             wr_c;
  logic [WIDTH-1:0] data_c;
  logic             incr_req_c;
  logic             done_c;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      g_q     <= g_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, datapath and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    a_d        = a_q;
    g_d        = g_q;
    addr_c     = x_sel;
    wr_c       = 1'b0;
    data_c     = g_q;
    incr_req_c = 1'b0;
    done_c     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (Run) begin
          ir_d       = DIN[WIDTH-1:6];
          incr_req_c = 1'b1;              // fetch advance, same cycle as accept
          state_d    = S_T1;
        end
      end

      S_T1: begin
        if (is_mv) begin
          addr_c  = y_sel;
          a_d     = q;
          state_d = S_T2;
        end else if (is_mvi) begin
          // DIN now carries the immediate; R7 also steps past it.
          addr_c     = x_sel;
          data_c     = DIN;
          wr_c       = 1'b1;
          incr_req_c = 1'b1;
          done_c     = 1'b1;
          state_d    = S_IDLE;
        end else if (is_arith) begin
          addr_c  = x_sel;
          a_d     = q;
          state_d = S_T2;
        end else begin
          done_c  = 1'b1;                 // nop completes immediately
          state_d = S_IDLE;
        end
      end

      S_T2: begin
        if (is_mv) begin
          addr_c  = x_sel;
          data_c  = a_q;
          wr_c    = 1'b1;
          done_c  = 1'b1;
          state_d = S_IDLE;
        end else if (is_arith) begin
          addr_c  = y_sel;
          g_d     = is_sub ? (a_q - q) : (a_q + q);
          state_d = S_T3;
        end else begin
          state_d = S_IDLE;               // unreachable for other opcodes
        end
      end

      S_T3: begin
        addr_c  = x_sel;
        data_c  = g_q;
        wr_c    = 1'b1;
        done_c  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // A write to R7 overrides the increment so mvi R7 lands the immediate
  // exactly. The reset term keeps the Mealy fetch strobe quiet while reset is
  // held low even if Run is asserted.
  assign rb_incr_pc = incr_req_c & ~(wr_c & (addr_c == PC_REG)) & reset;
  assign rb_addr    = addr_c;
  assign rb_wr      = wr_c;
  assign rb_data    = data_c;
  assign Done       = done_c;
  assign Busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_rb_sequencer.sv
module tb_rb_sequencer;

  localparam int WIDTH = 16;

  logic             Clock = 1'b0;
  logic             reset;
  logic             Run;
  logic [WIDTH-1:0] DIN;
  logic [WIDTH-1:0] q;
  logic [2:0]       rb_addr;
  logic             rb_wr;
  logic [WIDTH-1:0] rb_data;
  logic             rb_incr_pc;
  logic             Done;
  logic             Busy;

  rb_sequencer #(.WIDTH(WIDTH)) dut (
    .Clock      (Clock),
    .reset      (reset),
    .Run        (Run),
    .DIN        (DIN),
    .q          (q),
    .rb_addr    (rb_addr),
    .rb_wr      (rb_wr),
    .rb_data    (rb_data),
    .rb_incr_pc (rb_incr_pc),
    .Done       (Done),
    .Busy       (Busy)
  );

  always #5 Clock = ~Clock;

  // Register bank environment driven by the DUT, and the ISA-level reference.
  logic [WIDTH-1:0] bank [8];
  logic [WIDTH-1:0] ref_r [8];
  bit               load_req = 1'b0;

  assign q = bank[rb_addr];

  always @(posedge Clock) begin
    if (load_req) begin
      for (int i = 0; i < 8; i++) bank[i] <= ref_r[i];
    end else begin
      if (rb_wr) bank[rb_addr] <= rb_data;
      if (rb_incr_pc) bank[7] <= bank[7] + 16'd1;
    end
  end

  // Strobe counters over the active window of each instruction.
  bit mon_en = 1'b0;
  int mon_wr = 0;
  int mon_incr = 0;

  always @(posedge Clock) begin
    if (mon_en) begin
      mon_wr   <= mon_wr + int'(rb_wr);
      mon_incr <= mon_incr + int'(rb_incr_pc);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bank(input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_R%0d", tag, i), bank[i], ref_r[i]);
  endtask

  // Outputs captured in the Done cycle of the last instruction.
  logic [2:0]       d_addr;
  logic             d_wr;
  logic [WIDTH-1:0] d_data;
  logic             d_incr;

  task automatic run_instr(input logic [15:0] instr, input logic [15:0] imm, input bit hold);
    logic [3:0]  op;
    logic [2:0]  x;
    logic [2:0]  y;
    logic [15:0] exp_val;
    int          exp_lat;
    int          exp_incr;
    int          exp_wr;
    int          lat;
    int          w0;
    int          i0;
    bit          got_done;
    op = instr[15:12];
    x  = instr[11:9];
    y  = instr[8:6];

    // Architectural effect: fetch bumps the PC, then the opcode executes.
    ref_r[7] = ref_r[7] + 16'd1;
    exp_wr   = 1;
    exp_incr = 1;
    case (op)
      4'd0: begin ref_r[x] = ref_r[y]; exp_lat = 2; end
      4'd1: begin
        exp_lat = 1;
        if (x == 3'd7) ref_r[7] = imm;
        else begin
          ref_r[x] = imm;
          ref_r[7] = ref_r[7] + 16'd1;
          exp_incr = 2;
        end
      end
      4'd2: begin ref_r[x] = ref_r[x] + ref_r[y]; exp_lat = 3; end
      4'd3: begin ref_r[x] = ref_r[x] - ref_r[y]; exp_lat = 3; end
      default: begin exp_wr = 0; exp_lat = 1; end
    endcase
    exp_val = ref_r[x];

    @(negedge Clock);
    chk("idle_before", Busy, 1'b0);
    Run = 1'b1;
    DIN = instr;
    w0 = mon_wr;
    i0 = mon_incr;
    mon_en = 1'b1;
    #1 chk("fetch_incr", rb_incr_pc, 1'b1);
    @(posedge Clock);
    #1;
    Run = hold;
    DIN = imm;

    got_done = 1'b0;
    lat = 0;
    while (!got_done && lat < 6) begin
      @(negedge Clock);
      lat++;
      chk("busy", Busy, 1'b1);
      if (Done) begin
        got_done = 1'b1;
        d_addr = rb_addr;
        d_wr   = rb_wr;
        d_data = rb_data;
        d_incr = rb_incr_pc;
        Run    = 1'b0;
      end
    end
    Run = 1'b0;
    chk("done_seen", got_done, 1'b1);
    chk("latency", lat, exp_lat);
    @(posedge Clock);
    #1;
    mon_en = 1'b0;
    chk("wr_count", mon_wr - w0, exp_wr);
    chk("incr_count", mon_incr - i0, exp_incr);
    if (exp_wr != 0) begin
      chk("done_addr", d_addr, x);
      chk("done_data", d_data, exp_val);
    end
    chk_bank("bank");
    $display("[TB] instr 0x%04h imm 0x%04h hold %0d lat %0d wr_data 0x%04h", instr, imm, hold, lat, d_data);
  endtask

  initial begin
    logic [3:0] op;
    logic [2:0] x;
    logic [2:0] y;
    logic [5:0] lo;

    // Reset with Run asserted: every output must stay quiet.
    reset = 1'b0;
    Run   = 1'b1;
    DIN   = 16'h1200;
    for (int i = 0; i < 8; i++) ref_r[i] = 16'($urandom);
    load_req = 1'b1;
    @(posedge Clock);
    #1 load_req = 1'b0;
    @(posedge Clock);
    #1;
    chk("rst_busy", Busy, 1'b0);
    chk("rst_wr", rb_wr, 1'b0);
    chk("rst_incr", rb_incr_pc, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_addr", rb_addr, 3'd0);
    chk("rst_data", rb_data, 16'd0);
    chk_bank("rst_bank");
    @(negedge Clock);
    Run   = 1'b0;
    reset = 1'b1;
    #1;
    chk("rel_busy", Busy, 1'b0);
    chk("rel_addr", rb_addr, 3'd0);
    chk("rel_data", rb_data, 16'd0);
    chk("rel_incr", rb_incr_pc, 1'b0);

    // mvi R1,#0x00AB
    run_instr(16'h1200, 16'h00AB, 1'b0);
    chk("mvi_addr", d_addr, 3'd1);
    chk("mvi_wr", d_wr, 1'b1);
    chk("mvi_data", d_data, 16'h00AB);
    chk("mvi_incr", d_incr, 1'b1);

    // mv R3,R1
    run_instr(16'h0640, 16'h0000, 1'b0);
    chk("mv_data", d_data, 16'h00AB);

    // add wrap and sub borrow
    run_instr(16'h1400, 16'hFFFF, 1'b0);
    run_instr(16'h1600, 16'h0002, 1'b0);
    run_instr(16'h24C0, 16'h0000, 1'b0);
    chk("add_wrap", d_data, 16'h0001);
    run_instr(16'h1400, 16'h0001, 1'b0);
    run_instr(16'h34C0, 16'h0000, 1'b0);
    chk("sub_borrow", d_data, 16'hFFFF);

    // mvi R7: write wins over increment
    run_instr(16'h1E00, 16'h0040, 1'b0);
    chk("mvi_r7_incr", d_incr, 1'b0);
    chk("mvi_r7_data", d_data, 16'h0040);
    chk("mvi_r7_addr", d_addr, 3'd7);

    // Run held through an add, then an opcode-15 nop
    run_instr(16'h24C0, 16'h0000, 1'b1);
    run_instr(16'hF000, 16'h0000, 1'b0);
    chk("nop_wr", d_wr, 1'b0);

    // X=Y cases
    run_instr(16'h2480, 16'h0000, 1'b0);
    run_instr(16'h3480, 16'h0000, 1'b0);
    chk("sub_self", d_data, 16'h0000);

    // Reset during T2 of add aborts it with no write.
    @(negedge Clock);
    Run = 1'b1;
    DIN = 16'h24C0;
    ref_r[7] = ref_r[7] + 16'd1;
    @(posedge Clock);
    #1 Run = 1'b0;
    @(posedge Clock);
    #1 reset = 1'b0;
    #1;
    chk("abort_busy", Busy, 1'b0);
    chk("abort_wr", rb_wr, 1'b0);
    chk("abort_done", Done, 1'b0);
    chk("abort_addr", rb_addr, 3'd0);
    chk("abort_data", rb_data, 16'd0);
    @(posedge Clock);
    #1 chk_bank("abort_bank");
    @(negedge Clock);
    reset = 1'b1;
    run_instr(16'h0640, 16'h0000, 1'b0);

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      op = 4'($urandom_range(0, 4));
      if (op == 4'd4) op = 4'($urandom_range(4, 15));
      x  = 3'($urandom_range(0, 7));
      y  = 3'($urandom_range(0, 7));
      lo = 6'($urandom_range(0, 63));
      run_instr({op, x, y, lo}, 16'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rb_sequencer.md
# rb_sequencer

Multi-cycle control and datapath front end that drives the 8×16 register bank: it accepts one instruction word per Run handshake, decodes it, and sequences the bank's single shared address port through read and write-back cycles (mv, mvi, add, sub). It generates the bank's Wr, addr, data and incr_pc inputs and consumes its combinational read output q, so it is the master of the register-bank interface.

## Interface
- WIDTH, 16, data and instruction word width
- Clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- Run  input  1  request: DIN holds a valid instruction this cycle (sampled only in IDLE)
- DIN  input  WIDTH  instruction word; in mvi's T1 it carries the immediate
- q  input  WIDTH  register-bank read data for rb_addr (combinational)
- rb_addr  output  3  register-bank address (read and write)
- rb_wr  output  1  register-bank write enable
- rb_data  output  WIDTH  register-bank write data
- rb_incr_pc  output  1  PC (R7) increment strobe
- Done  output  1  one-cycle pulse on the instruction's final cycle
- Busy  output  1  high whenever state != IDLE

## Operation
- Instruction format: DIN[15:12] opcode, [11:9] X, [8:6] Y, [5:0] ignored. Opcodes: 0 mv Rx<-Ry; 1 mvi Rx<-imm; 2 add Rx<-Rx+Ry; 3 sub Rx<-Rx-Ry; 4-15 nop.
- Internal registers: IR, A, G (all WIDTH, reset 0); state IDLE, T1, T2, T3.
- IDLE: outputs idle. Run=1: IR<=DIN, rb_incr_pc=1 this cycle (fetch advance), go T1. Run=0: stay.
- mv: T1 rb_addr=Y, A<=q. T2 rb_addr=X, rb_data=A, rb_wr=1, Done=1, go IDLE.
- mvi: T1 rb_addr=X, rb_data=DIN, rb_wr=1, rb_incr_pc=1 (skip immediate), Done=1, go IDLE.
- add/sub: T1 rb_addr=X, A<=q. T2 rb_addr=Y, G<=A+q or A-q. T3 rb_addr=X, rb_data=G, rb_wr=1, Done=1, go IDLE.
- nop: T1 Done=1, no write, go IDLE.
- Arithmetic modulo 2^WIDTH; carry/borrow discarded; no flags.
- Write-wins rule: rb_incr_pc is forced 0 in any cycle where rb_wr=1 and rb_addr=7 (mvi R7 loads the immediate, no increment).
- Outside the listed cycles: rb_wr=0, rb_incr_pc=0, Done=0, rb_addr=IR[11:9] (X), rb_data=G.
- Run is ignored while Busy=1; no queuing.

## Timing
- All outputs combinational from state and IR; rb_incr_pc in IDLE additionally depends on Run (Mealy). All register updates on rising Clock.
- Reset (reset=0) asynchronously forces IDLE, IR=A=G=0; while low and after release: rb_wr=0, rb_incr_pc=0, Done=0, Busy=0, rb_addr=0, rb_data=0.
- Reset asserted mid-instruction aborts it; no write occurs in the abort cycle once reset is low.
- Latency from the accepting edge: nop/mvi Done in cycle 1, mv in cycle 2, add/sub in cycle 3; back-to-back throughput: next Run accepted in the cycle after Done.
- Bank write lands on the edge ending the Done cycle; the next instruction's T1 read sees the new value.
- X=Y allowed: add R2,R2 doubles R2; sub R2,R2 clears R2.

## Test plan
- Reset then mvi R1,#0x00AB (DIN=0x1200 with Run, then 0x00AB) -> T1: rb_addr=1, rb_wr=1, rb_data=0x00AB, rb_incr_pc=1, Done=1; two incr pulses total.
- R1=0x00AB, mv R3,R1 (0x0640) -> T1 rb_addr=1; T2 rb_addr=3, rb_data=0x00AB, rb_wr=1, Done=1.
- R2=0xFFFF, R3=0x0002, add R2,R3 (0x24C0) -> T3 rb_data=0x0001 (wrap); sub with R2=0x0001,R3=0x0002 (0x34C0) -> 0xFFFF.
- mvi R7,#0x0040 -> T1 rb_wr=1, rb_addr=7, rb_incr_pc=0, rb_data=0x0040.
- Run held high during add -> only one instruction accepted; Run re-sampled only after Done; opcode 0xF -> Done in T1, rb_wr never asserted.
- Assert reset in T2 of add -> immediate IDLE, Busy=0, no rb_wr in T3; next Run starts cleanly.
